// File: rtl/data_path.sv
// data_path: sixteen 32-bit registers on one shared bus that Mdatain drives when no register is selected
module data_path (
  input  logic        clr,
  input  logic        clk,
  input  logic [31:0] Mdatain,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R15out,
  input  logic        R0en,
  input  logic        R1en,
  input  logic        R2en,
  input  logic        R3en,
  input  logic        R4en,
  input  logic        R5en,
  input  logic        R6en,
  input  logic        R7en,
  input  logic        R8en,
  input  logic        R9en,
  input  logic        R10en,
  input  logic        R11en,
  input  logic        R12en,
  input  logic        R13en,
  input  logic        R14en,
  input  logic        R15en,
  output logic [31:0] BusMuxOut
);
  logic [15:0] sel, en;
  logic [31:0] r [16];
  logic [31:0] bus;
  assign sel = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign en  = {R15en, R14en, R13en, R12en, R11en, R10en, R9en, R8en,
                R7en, R6en, R5en, R4en, R3en, R2en, R1en, R0en};
  // scanning downward lets the lowest-indexed selected register win
  always_comb begin
    bus = Mdatain;
    for (int i = 15; i >= 0; i--) bus = sel[i] ? r[i] : bus;
  end
  assign BusMuxOut = bus;
  for (genvar g = 0; g < 16; g++) begin : g_reg
    always_ff @(posedge clk or negedge clr)
      if (!clr) r[g] <= '0;
      else if (en[g]) r[g] <= bus;
  end
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed plus random checks of data_path against a register-array model
`timescale 1ns/10ps
module tb_data_path;
  logic        clr = 1'b0, clk = 1'b0;
  logic [31:0] md = '0;
  logic [15:0] sel = '0, en = '0;
  logic [31:0] bus_o;
  logic [31:0] m [16];
  int total = 0, bad = 0;

  data_path dut (
    .clr(clr), .clk(clk), .Mdatain(md),
    .R0out(sel[0]), .R1out(sel[1]), .R2out(sel[2]), .R3out(sel[3]),
    .R4out(sel[4]), .R5out(sel[5]), .R6out(sel[6]), .R7out(sel[7]),
    .R8out(sel[8]), .R9out(sel[9]), .R10out(sel[10]), .R11out(sel[11]),
    .R12out(sel[12]), .R13out(sel[13]), .R14out(sel[14]), .R15out(sel[15]),
    .R0en(en[0]), .R1en(en[1]), .R2en(en[2]), .R3en(en[3]),
    .R4en(en[4]), .R5en(en[5]), .R6en(en[6]), .R7en(en[7]),
    .R8en(en[8]), .R9en(en[9]), .R10en(en[10]), .R11en(en[11]),
    .R12en(en[12]), .R13en(en[13]), .R14en(en[14]), .R15en(en[15]),
    .BusMuxOut(bus_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_bus();
    for (int i = 0; i < 16; i++) if (sel[i]) return m[i];
    return md;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [15:0] s, input logic [15:0] e, input logic [31:0] d);
    logic [31:0] b;
    sel = s; en = e; md = d;
    #1;
    b = model_bus();
    chk("bus", bus_o, b);
    @(posedge clk);
    if (clr) for (int i = 0; i < 16; i++) if (e[i]) m[i] = b;
    #1;
  endtask

  task automatic read_reg(input int k);
    sel = 16'(1) << k; en = '0;
    #0.25;
    chk($sformatf("R%0d", k), bus_o, m[k]);
  endtask

  task automatic read_all();
    for (int k = 0; k < 16; k++) read_reg(k);
  endtask

  initial begin
    logic [15:0] s, e;
    for (int i = 0; i < 16; i++) m[i] = '0;
    // reset with a write pending
    @(posedge clk); #1;
    apply(16'h0000, 16'h0008, 32'hFFFFFFFF);
    apply(16'h0000, 16'h0008, 32'hFFFFFFFF);
    chk("rst_bus_md", bus_o, 32'hFFFFFFFF);
    sel = 16'h0008; #0.25;
    chk("rst_bus_sel", bus_o, 32'h0);
    read_all();
    clr = 1'b1;
    // memory loads
    apply(16'h0000, 16'h0040, 32'h15);
    apply(16'h0000, 16'h0080, 32'h05);
    read_reg(6); chk("R6_const", bus_o, 32'h15);
    read_reg(7); chk("R7_const", bus_o, 32'h05);
    read_all();
    @(posedge clk); #1;
    // transfer R6 -> R2
    apply(16'h0040, 16'h0004, 32'hDEADBEEF);
    read_reg(2); chk("R2_const", bus_o, 32'h15);
    // priority and broadcast
    sel = 16'h00C0; en = '0; md = 32'h12345678; #1;
    chk("prio", bus_o, 32'h15);
    apply(16'h00C0, 16'h0C00, 32'h9);
    read_reg(10); chk("R10_const", bus_o, 32'h15);
    read_reg(11); chk("R11_const", bus_o, 32'h15);
    @(posedge clk); #1;
    // self write
    for (int i = 0; i < 3; i++) apply(16'h0080, 16'h0080, $urandom);
    read_reg(7); chk("R7_self", bus_o, 32'h05);
    @(posedge clk); #1;
    // random traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: s = '0;
        1: s = 16'(1) << $urandom_range(0, 15);
        2: s = 16'($urandom) & 16'($urandom);
        default: s = 16'($urandom);
      endcase
      e = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'(1) << $urandom_range(0, 15);
      apply(s, e, $urandom);
      if (n % 50 == 49) begin
        read_all();
        @(posedge clk); #1;
      end
    end
    // async reset between edges
    sel = '0; en = '0;
    clr = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = '0;
    read_all();
    apply(16'h0000, 16'h8000, 32'h77777777);
    read_reg(15);
    @(posedge clk); #1;
    clr = 1'b1;
    apply(16'h0000, 16'h8000, 32'hA5A5A5A5);
    read_reg(15); chk("R15_const", bus_o, 32'hA5A5A5A5);
    read_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
